// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and the
// load/store stage. Data requests win, and every access lasts a fixed LAT cycles.
module mem_arbiter #(
  parameter int AW  = 7,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          stall_if,
  output logic          stall_mem,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       is_wr;
  logic       d_req;
  logic       last;
  logic       grant_if;
  logic       grant_d;

  assign d_req = d_rd | d_wr;
  assign busy  = (state == IF_BUSY) | (state == D_BUSY);
  assign last  = busy & (cnt == CNT_LAST);

  // Arbitration; in a last cycle the requester just served is not reconsidered.
  always_comb begin
    state_nx = state;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req) begin
          grant_d  = 1'b1;
          state_nx = D_BUSY;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_nx = IF_BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      IF_BUSY: begin
        if (last) begin
          if (d_req) begin
            grant_d  = 1'b1;
            state_nx = D_BUSY;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = IF_BUSY;
        end
      end
      D_BUSY: begin
        if (last) begin
          if (if_req) begin
            grant_if = 1'b1;
            state_nx = IF_BUSY;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = D_BUSY;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Access counter plus address/data/direction captured at grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      is_wr     <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= 32'd0;
    end else if (grant_d) begin
      cnt       <= 4'd0;
      is_wr     <= d_wr;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (grant_if) begin
      cnt      <= 4'd0;
      is_wr    <= 1'b0;
      mem_addr <= if_addr;
    end else if (last) begin
      cnt <= 4'd0;
    end else if (busy) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Strobes come only from flops so a changing request cannot glitch them.
  assign if_ack    = (state == IF_BUSY) & last;
  assign d_ack     = (state == D_BUSY) & last;
  assign mem_rd    = (state == IF_BUSY) | ((state == D_BUSY) & ~is_wr);
  assign mem_wr    = (state == D_BUSY) & is_wr & last;
  assign if_rdata  = if_ack ? mem_rdata : 32'd0;
  assign d_rdata   = (d_ack & ~is_wr) ? mem_rdata : 32'd0;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  mem_arbiter_checker #(.AW(AW)) u_checker (
    .clk      (clk),
    .reset    (reset),
    .if_ack   (if_ack),
    .d_ack    (d_ack),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .busy     (busy),
    .mem_addr (mem_addr)
  );

endmodule

// mem_arbiter_checker: protocol properties of the arbiter's memory side.
module mem_arbiter_checker #(
  parameter int AW = 7
) (
  input logic          clk,
  input logic          reset,
  input logic          if_ack,
  input logic          d_ack,
  input logic          mem_rd,
  input logic          mem_wr,
  input logic          busy,
  input logic [AW-1:0] mem_addr
);

  a_single_ack: assert property (@(posedge clk) disable iff (reset) !(if_ack && d_ack));
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset) !(mem_rd && mem_wr));
  a_wr_at_ack:  assert property (@(posedge clk) disable iff (reset) mem_wr |-> d_ack);
  // Address may only move at a grant, which follows an ack or IDLE.
  a_addr_hold:  assert property (@(posedge clk) disable iff (reset)
                  (busy && !if_ack && !d_ack) |=> $stable(mem_addr));

endmodule
